// File: rtl/quad_decoder.sv
// Quadrature encoder decoder: turns debounced A/B edges into a position value
// with one-cycle detent and illegal-transition pulses.
module quad_decoder #(
    parameter int               WIDTH       = 8,
    parameter int               STEP        = 1,
    parameter int               SATURATE    = 0,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             a,
    input  logic             b,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] value,
    output logic             up_pulse,
    output logic             down_pulse,
    output logic             error_pulse
);

    localparam logic [WIDTH:0] STEP_EXT = (WIDTH+1)'(STEP);

    logic [1:0]        cur_ab;
    logic [1:0]        prev_ab;
    logic signed [3:0] acc;
    logic signed [3:0] acc_step;
    logic signed [3:0] acc_upd;
    logic signed [3:0] acc_next;
    logic              fwd;
    logic              rev;
    logic              illegal;
    logic              land_zero;
    logic              detent_up;
    logic              detent_down;
    logic [WIDTH:0]    sum_ext;
    logic [WIDTH:0]    diff_ext;
    logic [WIDTH-1:0]  inc_value;
    logic [WIDTH-1:0]  dec_value;
    logic [WIDTH-1:0]  value_next;

    always_comb begin
        cur_ab = {a, b};
        fwd    = 1'b0;
        rev    = 1'b0;
        case ({prev_ab, cur_ab})
            4'b0001, 4'b0111, 4'b1110, 4'b1000: fwd = 1'b1;
            4'b0010, 4'b1011, 4'b1101, 4'b0100: rev = 1'b1;
            default: ;
        endcase
        illegal   = ((prev_ab ^ cur_ab) == 2'b11);
        acc_step  = fwd ? 4'sd1 : (rev ? -4'sd1 : 4'sd0);
        acc_upd   = acc + acc_step;
        land_zero = (fwd || rev) && (cur_ab == 2'b00);
        // A detent only counts after four consistent steps ending at rest (00).
        detent_up   = land_zero && (acc_upd == 4'sd4);
        detent_down = land_zero && (acc_upd == -4'sd4);
        acc_next    = (illegal || land_zero) ? 4'sd0 : acc_upd;
    end

    // Extra MSB catches carry/borrow for the clamping variant.
    always_comb begin
        sum_ext   = {1'b0, value} + STEP_EXT;
        diff_ext  = {1'b0, value} - STEP_EXT;
        inc_value = ((SATURATE != 0) && sum_ext[WIDTH])  ? '1 : sum_ext[WIDTH-1:0];
        dec_value = ((SATURATE != 0) && diff_ext[WIDTH]) ? '0 : diff_ext[WIDTH-1:0];
        if (load)
            value_next = load_value;
        else if (detent_up)
            value_next = inc_value;
        else if (detent_down)
            value_next = dec_value;
        else
            value_next = value;
    end

    always_ff @(posedge clk) begin
        prev_ab <= cur_ab;
        if (reset) begin
            value       <= RESET_VALUE;
            acc         <= 4'sd0;
            up_pulse    <= 1'b0;
            down_pulse  <= 1'b0;
            error_pulse <= 1'b0;
        end else begin
            value       <= value_next;
            acc         <= acc_next;
            up_pulse    <= detent_up && !load;
            down_pulse  <= detent_down && !load;
            error_pulse <= illegal;
        end
    end

endmodule

// File: tb/tb_quad_decoder.sv
// Directed bench for quad_decoder: wrapping default instance driven from a
// vector table, plus a saturating STEP=5 instance exercised by hand sequences.
module tb_quad_decoder;

    logic       clk = 1'b0;
    logic       reset;
    logic       a;
    logic       b;
    logic       load;
    logic [7:0] load_value;
    logic [7:0] value;
    logic       up_pulse;
    logic       down_pulse;
    logic       error_pulse;
    logic       load_s;
    logic [7:0] load_value_s;
    logic [7:0] value_s;
    logic       up_s;
    logic       down_s;
    logic       err_s;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    quad_decoder dut (
        .clk(clk), .reset(reset), .a(a), .b(b),
        .load(load), .load_value(load_value),
        .value(value), .up_pulse(up_pulse),
        .down_pulse(down_pulse), .error_pulse(error_pulse)
    );

    quad_decoder #(.WIDTH(8), .STEP(5), .SATURATE(1), .RESET_VALUE(8'd0)) dut_sat (
        .clk(clk), .reset(reset), .a(a), .b(b),
        .load(load_s), .load_value(load_value_s),
        .value(value_s), .up_pulse(up_s),
        .down_pulse(down_s), .error_pulse(err_s)
    );

    typedef struct {
        logic       rst;
        logic [1:0] ab;
        logic       ld;
        logic [7:0] lv;
        logic [7:0] ev;
        logic       eu;
        logic       ed;
        logic       ee;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic rst, input logic [1:0] ab, input logic ld,
                                input logic [7:0] lv, input logic [7:0] ev,
                                input logic eu, input logic ed, input logic ee);
        vec_t v;
        v.rst = rst; v.ab = ab; v.ld = ld; v.lv = lv;
        v.ev = ev; v.eu = eu; v.ed = ed; v.ee = ee;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input int idx, input logic [7:0] act,
                       input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic step_sat(input logic [1:0] ab, input logic ld, input logic [7:0] lv);
        a = ab[1]; b = ab[0]; load_s = ld; load_value_s = lv;
        @(posedge clk); #1;
    endtask

    task automatic chk_sat(input int idx, input logic [7:0] ev, input logic eu,
                           input logic ed);
        chk("sat_value", idx, value_s, ev);
        chk("sat_up",    idx, {7'd0, up_s}, {7'd0, eu});
        chk("sat_down",  idx, {7'd0, down_s}, {7'd0, ed});
        chk("sat_err",   idx, {7'd0, err_s}, 8'd0);
    endtask

    initial begin
        reset = 1'b1; a = 1'b0; b = 1'b0; load = 1'b0; load_value = 8'd0;
        load_s = 1'b0; load_value_s = 8'd0;

        //   rst ab     ld lv      value   up dn err
        add(1, 2'b00, 0, 8'h00, 8'h00, 0, 0, 0);   // reset state
        add(0, 2'b00, 0, 8'h00, 8'h00, 0, 0, 0);
        // clockwise detent, two cycles per state
        add(0, 2'b01, 0, 8'h00, 8'h00, 0, 0, 0);
        add(0, 2'b01, 0, 8'h00, 8'h00, 0, 0, 0);
        add(0, 2'b11, 0, 8'h00, 8'h00, 0, 0, 0);
        add(0, 2'b11, 0, 8'h00, 8'h00, 0, 0, 0);
        add(0, 2'b10, 0, 8'h00, 8'h00, 0, 0, 0);
        add(0, 2'b10, 0, 8'h00, 8'h00, 0, 0, 0);
        add(0, 2'b00, 0, 8'h00, 8'h01, 1, 0, 0);
        add(0, 2'b00, 0, 8'h00, 8'h01, 0, 0, 0);
        // load 0 then counter-clockwise detent wraps to 255
        add(0, 2'b00, 1, 8'h00, 8'h00, 0, 0, 0);
        add(0, 2'b10, 0, 8'h00, 8'h00, 0, 0, 0);
        add(0, 2'b11, 0, 8'h00, 8'h00, 0, 0, 0);
        add(0, 2'b01, 0, 8'h00, 8'h00, 0, 0, 0);
        add(0, 2'b00, 0, 8'h00, 8'hFF, 0, 1, 0);
        add(0, 2'b00, 0, 8'h00, 8'hFF, 0, 0, 0);
        // illegal 11->00, then partial 00->01->00
        add(0, 2'b01, 0, 8'h00, 8'hFF, 0, 0, 0);
        add(0, 2'b11, 0, 8'h00, 8'hFF, 0, 0, 0);
        add(0, 2'b00, 0, 8'h00, 8'hFF, 0, 0, 1);
        add(0, 2'b00, 0, 8'h00, 8'hFF, 0, 0, 0);
        add(0, 2'b01, 0, 8'h00, 8'hFF, 0, 0, 0);
        add(0, 2'b00, 0, 8'h00, 8'hFF, 0, 0, 0);
        add(0, 2'b00, 0, 8'h00, 8'hFF, 0, 0, 0);
        // load 0x80 on the detent-completing edge
        add(0, 2'b01, 0, 8'h00, 8'hFF, 0, 0, 0);
        add(0, 2'b11, 0, 8'h00, 8'hFF, 0, 0, 0);
        add(0, 2'b10, 0, 8'h00, 8'hFF, 0, 0, 0);
        add(0, 2'b00, 1, 8'h80, 8'h80, 0, 0, 0);
        add(0, 2'b00, 0, 8'h00, 8'h80, 0, 0, 0);
        // accumulator was cleared: next detent counts normally
        add(0, 2'b01, 0, 8'h00, 8'h80, 0, 0, 0);
        add(0, 2'b11, 0, 8'h00, 8'h80, 0, 0, 0);
        add(0, 2'b10, 0, 8'h00, 8'h80, 0, 0, 0);
        add(0, 2'b00, 0, 8'h00, 8'h81, 1, 0, 0);
        add(0, 2'b00, 0, 8'h00, 8'h81, 0, 0, 0);
        // reset mid-detent, release at 11, finish 10,00
        add(0, 2'b01, 0, 8'h00, 8'h81, 0, 0, 0);
        add(0, 2'b11, 0, 8'h00, 8'h81, 0, 0, 0);
        add(1, 2'b11, 0, 8'h00, 8'h00, 0, 0, 0);
        add(0, 2'b11, 0, 8'h00, 8'h00, 0, 0, 0);
        add(0, 2'b10, 0, 8'h00, 8'h00, 0, 0, 0);
        add(0, 2'b00, 0, 8'h00, 8'h00, 0, 0, 0);
        add(0, 2'b00, 0, 8'h00, 8'h00, 0, 0, 0);
        // 255 + 1 wraps to 0
        add(0, 2'b00, 1, 8'hFF, 8'hFF, 0, 0, 0);
        add(0, 2'b01, 0, 8'h00, 8'hFF, 0, 0, 0);
        add(0, 2'b11, 0, 8'h00, 8'hFF, 0, 0, 0);
        add(0, 2'b10, 0, 8'h00, 8'hFF, 0, 0, 0);
        add(0, 2'b00, 0, 8'h00, 8'h00, 1, 0, 0);
        // reset beats load
        add(1, 2'b00, 1, 8'h55, 8'h00, 0, 0, 0);
        add(0, 2'b00, 0, 8'h00, 8'h00, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            reset = vecs[i].rst; a = vecs[i].ab[1]; b = vecs[i].ab[0];
            load = vecs[i].ld; load_value = vecs[i].lv;
            @(posedge clk); #1;
            chk("value", i, value, vecs[i].ev);
            chk("up",    i, {7'd0, up_pulse},    {7'd0, vecs[i].eu});
            chk("down",  i, {7'd0, down_pulse},  {7'd0, vecs[i].ed});
            chk("error", i, {7'd0, error_pulse}, {7'd0, vecs[i].ee});
        end

        // Saturating instance: clamp high, clamp low, clamp again at 0.
        reset = 1'b0; load = 1'b0;
        step_sat(2'b00, 1, 8'd253); chk_sat(100, 8'd253, 0, 0);
        step_sat(2'b01, 0, 8'd0);   chk_sat(101, 8'd253, 0, 0);
        step_sat(2'b11, 0, 8'd0);   chk_sat(102, 8'd253, 0, 0);
        step_sat(2'b10, 0, 8'd0);   chk_sat(103, 8'd253, 0, 0);
        step_sat(2'b00, 0, 8'd0);   chk_sat(104, 8'd255, 1, 0);
        step_sat(2'b00, 0, 8'd0);   chk_sat(105, 8'd255, 0, 0);
        step_sat(2'b00, 1, 8'd3);   chk_sat(106, 8'd3,   0, 0);
        step_sat(2'b10, 0, 8'd0);   chk_sat(107, 8'd3,   0, 0);
        step_sat(2'b11, 0, 8'd0);   chk_sat(108, 8'd3,   0, 0);
        step_sat(2'b01, 0, 8'd0);   chk_sat(109, 8'd3,   0, 0);
        step_sat(2'b00, 0, 8'd0);   chk_sat(110, 8'd0,   0, 1);
        step_sat(2'b00, 0, 8'd0);   chk_sat(111, 8'd0,   0, 0);
        step_sat(2'b10, 0, 8'd0);   chk_sat(112, 8'd0,   0, 0);
        step_sat(2'b11, 0, 8'd0);   chk_sat(113, 8'd0,   0, 0);
        step_sat(2'b01, 0, 8'd0);   chk_sat(114, 8'd0,   0, 0);
        step_sat(2'b00, 0, 8'd0);   chk_sat(115, 8'd0,   0, 1);
        // unsaturated step of 5 from the middle of the range
        step_sat(2'b00, 1, 8'd100); chk_sat(116, 8'd100, 0, 0);
        step_sat(2'b01, 0, 8'd0);   chk_sat(117, 8'd100, 0, 0);
        step_sat(2'b11, 0, 8'd0);   chk_sat(118, 8'd100, 0, 0);
        step_sat(2'b10, 0, 8'd0);   chk_sat(119, 8'd100, 0, 0);
        step_sat(2'b00, 0, 8'd0);   chk_sat(120, 8'd105, 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
